// File: rtl/disp_conv_sched.sv
// Round-robin scheduler sharing one combinational bin->dec converter between two
// sources, then time-multiplexing sign + five digits onto a 6-position display.
module disp_conv_sched #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [15:0] val0_i,
  input  logic [15:0] val1_i,
  output logic [1:0]  gnt_o,
  output logic [15:0] conv_bin_o,
  input  logic [39:0] conv_dec_i,
  input  logic [7:0]  conv_sign_i,
  output logic [7:0]  digit_o,
  output logic [5:0]  sel_o,
  output logic        src_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN
  } state_t;

  localparam logic [7:0] BLANK    = 8'h0F;
  localparam logic [7:0] NEG      = 8'h0D;
  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [2:0] POS_LAST = 3'd5;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [15:0]     bin_q, bin_d;
  logic            src_q, src_d;
  logic            last_q, last_d;
  logic [4:0][7:0] dig_q, dig_d;
  logic            neg_q, neg_d;
  logic [2:0]      pos_q, pos_d;
  logic [7:0]      div_q, div_d;

  logic       frame_end;
  logic       arb_en;
  logic       win;
  logic [4:0] upper_zero;

  always_comb begin
    frame_end = (state_q == ST_SCAN) && (pos_q == POS_LAST) && (div_q == DIV_LAST);
    arb_en    = ((state_q == ST_IDLE) || frame_end) && (req_i != 2'b00);
    // With both requesting, the source not granted last wins
    win       = (req_i == 2'b11) ? ~last_q : req_i[1];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    bin_d   = bin_q;
    src_d   = src_q;
    last_d  = last_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    pos_d   = pos_q;
    div_d   = div_q;
    if (arb_en) begin
      state_d = ST_LOAD;
      gnt_d   = win ? 2'b10 : 2'b01;
      bin_d   = win ? val1_i : val0_i;
      src_d   = win;
      last_d  = win;
    end else begin
      case (state_q)
        ST_LOAD: begin
          dig_d   = conv_dec_i;
          neg_d   = (conv_sign_i == NEG);
          pos_d   = '0;
          div_d   = '0;
          state_d = ST_SCAN;
        end
        ST_SCAN: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 3'd1;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      bin_q   <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      dig_q   <= '0;
      neg_q   <= 1'b0;
      pos_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      bin_q   <= bin_d;
      src_q   <= src_d;
      last_q  <= last_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
    end
  end

  // upper_zero[k]: digit k and every more significant digit are zero
  always_comb begin
    upper_zero[4] = (dig_q[4] == 8'h00);
    upper_zero[3] = upper_zero[4] && (dig_q[3] == 8'h00);
    upper_zero[2] = upper_zero[3] && (dig_q[2] == 8'h00);
    upper_zero[1] = upper_zero[2] && (dig_q[1] == 8'h00);
    upper_zero[0] = upper_zero[1] && (dig_q[0] == 8'h00);
  end

  always_comb begin
    digit_o = BLANK;
    sel_o   = '0;
    if (state_q == ST_SCAN) begin
      sel_o = 6'b000001 << pos_q;
      case (pos_q)
        3'd0:                digit_o = dig_q[0];
        3'd1, 3'd2, 3'd3,
        3'd4:                digit_o = upper_zero[pos_q] ? BLANK : dig_q[pos_q];
        default:             digit_o = neg_q ? NEG : BLANK;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign conv_bin_o = bin_q;
  assign src_o      = src_q;
  assign valid_o    = (state_q == ST_SCAN);

endmodule

// File: tb/tb_disp_conv_sched.sv
// Bench for disp_conv_sched: behavioural frame-time model checked every cycle,
// plus literal display sequences, grant ordering/latency and async-reset checks.
module tb_disp_conv_sched;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] val0 = '0;
  logic [15:0] val1 = '0;
  logic [1:0]  gnt_o;
  logic [15:0] conv_bin_o;
  logic [39:0] conv_dec;
  logic [7:0]  conv_sign;
  logic [7:0]  digit_o;
  logic [5:0]  sel_o;
  logic        src_o;
  logic        valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  disp_conv_sched #(.SCAN_DIV(SD)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .val0_i     (val0),
    .val1_i     (val1),
    .gnt_o      (gnt_o),
    .conv_bin_o (conv_bin_o),
    .conv_dec_i (conv_dec),
    .conv_sign_i(conv_sign),
    .digit_o    (digit_o),
    .sel_o      (sel_o),
    .src_o      (src_o),
    .valid_o    (valid_o)
  );

  always #5 clk = ~clk;

  // Shared converter stand-in: magnitude digits, units first, plus sign code
  function automatic logic [39:0] to_dec(input logic [15:0] b);
    int mag;
    logic [39:0] r;
    mag = $signed(b);
    if (mag < 0) mag = -mag;
    for (int k = 0; k < 5; k++) begin
      r[8*k +: 8] = 8'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  assign conv_dec  = to_dec(conv_bin_o);
  assign conv_sign = conv_bin_o[15] ? 8'h0D : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode plus a cycle index within the 6*SD frame
  typedef enum int {M_IDLE, M_LOAD, M_SCAN} mmode_t;
  mmode_t      m_mode;
  int          m_t;
  logic [15:0] m_bin;
  logic        m_src, m_last;
  logic [1:0]  m_gnt;
  logic        m_win, m_arb;

  assign m_win = (req == 2'b11) ? ~m_last : req[1];
  assign m_arb = (m_mode == M_IDLE || (m_mode == M_SCAN && m_t == 6*SD - 1)) && (req != 2'b00);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_t    <= 0;
      m_bin  <= '0;
      m_src  <= 1'b0;
      m_last <= 1'b1;
      m_gnt  <= '0;
    end else begin
      m_gnt <= '0;
      if (m_arb) begin
        m_mode <= M_LOAD;
        m_last <= m_win;
        m_src  <= m_win;
        m_bin  <= m_win ? val1 : val0;
        m_gnt  <= m_win ? 2'b10 : 2'b01;
      end else if (m_mode == M_LOAD) begin
        m_mode <= M_SCAN;
        m_t    <= 0;
      end else if (m_mode == M_SCAN) begin
        m_t <= (m_t + 1) % (6*SD);
      end
    end
  end

  function automatic logic [5:0] exp_sel();
    if (m_mode != M_SCAN) return 6'b0;
    return 6'b000001 << (m_t / SD);
  endfunction

  function automatic logic [7:0] exp_digit();
    int v, mag, pos, pw;
    if (m_mode != M_SCAN) return 8'h0F;
    v   = $signed(m_bin);
    mag = (v < 0) ? -v : v;
    pos = m_t / SD;
    if (pos == 5) return (v < 0) ? 8'h0D : 8'h0F;
    pw = 1;
    for (int i = 0; i < pos; i++) pw = pw * 10;
    if (pos > 0 && mag < pw) return 8'h0F;
    return 8'((mag / pw) % 10);
  endfunction

  always @(negedge clk) begin
    chk("gnt", 32'(gnt_o), 32'(m_gnt));
    chk("conv_bin", 32'(conv_bin_o), 32'(m_bin));
    chk("src", 32'(src_o), 32'(m_src));
    chk("valid", 32'(valid_o), 32'(m_mode == M_SCAN));
    chk("sel", 32'(sel_o), 32'(exp_sel()));
    chk("digit", 32'(digit_o), 32'(exp_digit()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget, output int n);
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (gnt_o != 2'b00) ok = 1'b1;
    end
    chk("gnt_timeout", 32'(ok), 32'd1);
  endtask

  // Called at the first cycle of a frame; e[p] is the code for position p
  task automatic check_frame(input string nm, input logic [5:0][7:0] e);
    logic [5:0] s;
    for (int p = 0; p < 6; p++) begin
      s = 6'b000001 << p;
      chk({nm, "_sel"}, 32'(sel_o), 32'(s));
      chk({nm, "_digit"}, 32'(digit_o), 32'(e[p]));
      repeat (SD) tick();
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_sel"}, 32'(sel_o), 32'd0);
    chk({nm, "_gnt"}, 32'(gnt_o), 32'd0);
    chk({nm, "_valid"}, 32'(valid_o), 32'd0);
    chk({nm, "_digit"}, 32'(digit_o), 32'h0F);
    chk({nm, "_bin"}, 32'(conv_bin_o), 32'd0);
    chk({nm, "_src"}, 32'(src_o), 32'd0);
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'($signed($urandom_range(0, 40)) - 20);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    check_reset_outputs("rst_init");
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check_reset_outputs("idle_hold");

    // Single conversion, source 0
    val0 = 16'd12345;
    req  = 2'b01;
    wait_gnt(10, n);
    chk("lat_gnt", 32'(n), 32'd1);
    chk("gnt_first", 32'(gnt_o), 32'h1);
    chk("dark_load", 32'(sel_o), 32'd0);
    req = 2'b00;
    tick();
    chk("gnt_fall", 32'(gnt_o), 32'd0);
    check_frame("f12345", {8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    check_frame("f12345_rep", {8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

    // Negative value on source 1
    val1 = 16'hFFF6;
    req  = 2'b10;
    wait_gnt(6*SD + 5, n);
    chk("gnt_neg", 32'(gnt_o), 32'h2);
    req = 2'b00;
    tick();
    chk("src_neg", 32'(src_o), 32'd1);
    check_frame("fneg", {8'h0D, 8'h0F, 8'h0F, 8'h0F, 8'h01, 8'h00});

    // Zero on source 1
    val1 = 16'd0;
    req  = 2'b10;
    wait_gnt(6*SD + 5, n);
    req = 2'b00;
    tick();
    check_frame("fzero", {8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00});

    // Both sources holding requests: alternation with one dark cycle each
    val0 = 16'd111;
    val1 = 16'd222;
    req  = 2'b11;
    for (int g = 0; g < 3; g++) begin
      wait_gnt(6*SD + 5, n);
      chk("rr_gnt", 32'(gnt_o), (g % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_src", 32'(src_o), (g % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_dark", 32'(sel_o), 32'd0);
      if (g > 0) chk("rr_spacing", 32'(n), 32'(6*SD + 1));
    end
    req = 2'b00;
    tick();
    chk("rr_first_pos", 32'(sel_o), 32'h01);

    // Request raised in the last cycle of position 2
    repeat (2*SD) tick();
    chk("mid_pos2", 32'(sel_o), 32'h04);
    repeat (SD - 1) tick();
    val1 = 16'd777;
    req  = 2'b10;
    wait_gnt(8*SD, n);
    chk("mid_latency", 32'(n), 32'(3*SD + 1));
    chk("mid_gnt", 32'(gnt_o), 32'h2);
    req = 2'b00;

    // Asynchronous reset at position 3 while a request is pending
    tick();
    repeat (3*SD) tick();
    chk("rst_pos3", 32'(sel_o), 32'h08);
    val0 = 16'd555;
    req  = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_no_gnt", 32'(gnt_o), 32'd0);
    tick();
    chk("rst_regrant", 32'(gnt_o), 32'h1);
    chk("rst_regrant_bin", 32'(conv_bin_o), 32'd555);
    req = 2'b00;

    // Randomized requesters, checked by the per-cycle model compare
    for (int c = 0; c < 2500; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (req[i] && gnt_o[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 14) == 0) begin
          if (i == 0) val0 = rand_val();
          else        val1 = rand_val();
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end

    req = 2'b00;
    repeat (8*SD) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
